debounce_multi: RTL and testbench

Parametrised multi-channel push-button/switch debouncer. It synchronises N asynchronous inputs and filters each one with its own consecutive-sample counter, driven by a shared sample-tick prescaler. Each channel produces a clean level and optional one-cycle rise/fall pulses. It sits between board-level buttons/switches and the control FSMs, and replaces single-channel shift-register debouncing.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_chan.sv | 82 ++++++++
 rtl/debounce_multi.sv | 62 ++++++
 tb/tb_debounce_multi.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

    localparam int unsigned DEF_CHANNELS     = 4;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_TICK_DIV     = 1000;
    localparam int unsigned DEF_STABLE_TICKS = 8;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, consecutive-tick counter, level and edge flops.
// Edge pulses are built only when DEBOUNCE_EDGE_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pb,
    input  logic tick,
    input  logic clear,
    output logic semnal,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW      = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   flip_c;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pb};
        end
    end

    // Count consecutive ticks on which the synchronised input disagrees with the level.
    always_comb begin
        cnt_d  = cnt_q;
        flip_c = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            if (s == semnal) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                flip_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            semnal <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            semnal <= semnal ^ flip_c;
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    // Pulses land in the same cycle the level shows its new value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= flip_c & ~semnal;
            fall <= flip_c & semnal;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample-tick prescaler feeding CHANNELS debounce_chan instances.
// Optional rise/fall pulses are enabled by defining DEBOUNCE_EDGE_EN.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS     = DEF_CHANNELS,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] pb,
    input  logic                clear,
    output logic [CHANNELS-1:0] semnal,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int unsigned   PW      = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] DIV_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    // Prescaler wraps at TICK_DIV-1; clear restarts the phase.
    always_comb begin
        pcnt_d = pcnt_q + PW'(1);
        if (clear || (pcnt_q == DIV_MAX)) begin
            pcnt_d = '0;
        end
    end

    // tick is registered from the next count so it is high exactly while count==TICK_DIV-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
            tick   <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick   <= (pcnt_d == DIV_MAX);
        end
    end

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .pb      (pb[i]),
            .tick    (tick),
            .clear   (clear),
            .semnal  (semnal[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (every-cycle sampling and a /5 prescaler)
// checked each cycle against a run-length model, plus hand-computed spot values.
module tb_debounce_multi;

    localparam int unsigned CH    = 4;
    localparam int unsigned SS    = 2;
    localparam int unsigned DIV_A = 1;
    localparam int unsigned ST_A  = 4;
    localparam int unsigned DIV_B = 5;
    localparam int unsigned ST_B  = 3;
`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] pb_a = '1, pb_b = '1;
    logic          clear_a = 1'b0, clear_b = 1'b0;
    logic [CH-1:0] semnal_a, rise_a, fall_a, semnal_b, rise_b, fall_b;
    logic          tick_a, tick_b;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    debounce_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .TICK_DIV(DIV_A), .STABLE_TICKS(ST_A)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .pb(pb_a), .clear(clear_a),
        .semnal(semnal_a), .rise(rise_a), .fall(fall_a), .tick(tick_a)
    );

    debounce_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .TICK_DIV(DIV_B), .STABLE_TICKS(ST_B)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .pb(pb_b), .clear(clear_b),
        .semnal(semnal_b), .rise(rise_b), .fall(fall_b), .tick(tick_b)
    );

    // Model: s is pb delayed SS edges; a level flips once ST consecutive ticks disagree with it.
    logic [CH-1:0] m_pipe [2][SS];
    int unsigned   m_since [2];
    logic          m_tick [2];
    int unsigned   m_run [2][CH];
    logic [CH-1:0] m_lvl [2];
    logic [CH-1:0] m_rise [2];
    logic [CH-1:0] m_fall [2];

    function automatic int unsigned div_of(input int d);
        return (d == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic int unsigned st_of(input int d);
        return (d == 0) ? ST_A : ST_B;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < int'(SS); k++) m_pipe[d][k] = '0;
            for (int c = 0; c < int'(CH); c++) m_run[d][c] = 0;
            m_since[d] = 0;
            m_tick[d]  = 1'b0;
            m_lvl[d]   = '0;
            m_rise[d]  = '0;
            m_fall[d]  = '0;
        end
    endtask

    task automatic model_edge(input int d, input logic [CH-1:0] pbv, input logic clr);
        logic [CH-1:0] s;
        s = m_pipe[d][SS-1];
        m_rise[d] = '0;
        m_fall[d] = '0;
        for (int c = 0; c < int'(CH); c++) begin
            if (clr) begin
                m_run[d][c] = 0;
            end else if (m_tick[d]) begin
                if (s[c] == m_lvl[d][c]) begin
                    m_run[d][c] = 0;
                end else begin
                    m_run[d][c] = m_run[d][c] + 1;
                    if (m_run[d][c] == st_of(d)) begin
                        m_run[d][c]  = 0;
                        m_lvl[d][c]  = s[c];
                        m_rise[d][c] = s[c];
                        m_fall[d][c] = ~s[c];
                    end
                end
            end
        end
        for (int k = int'(SS) - 1; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
        m_pipe[d][0] = pbv;
        m_since[d] = clr ? 0 : m_since[d] + 1;
        m_tick[d]  = ((m_since[d] % div_of(d)) == div_of(d) - 1);
    endtask

    task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Advance one clock edge, update the model with the inputs seen at that edge, compare all outputs.
    task automatic step();
        logic [CH-1:0] pa, pbv;
        logic ca, cb, rn;
        pa = pb_a; pbv = pb_b; ca = clear_a; cb = clear_b; rn = reset_n;
        @(posedge clock);
        #1;
        if (!rn) begin
            model_reset();
        end else begin
            model_edge(0, pa, ca);
            model_edge(1, pbv, cb);
        end
        chk("a_semnal", semnal_a, m_lvl[0]);
        chk("a_rise",   rise_a,   EDGE_EN ? m_rise[0] : '0);
        chk("a_fall",   fall_a,   EDGE_EN ? m_fall[0] : '0);
        chk("a_tick",   CH'(tick_a), CH'(m_tick[0]));
        chk("b_semnal", semnal_b, m_lvl[1]);
        chk("b_rise",   rise_b,   EDGE_EN ? m_rise[1] : '0);
        chk("b_fall",   fall_b,   EDGE_EN ? m_fall[1] : '0);
        chk("b_tick",   CH'(tick_b), CH'(m_tick[1]));
    endtask

    initial begin
        int nt;
        model_reset();

        // Reset held with all inputs high.
        repeat (3) step();
        chk("lit_reset_semnal", semnal_a, 4'b0000);
        chk("lit_reset_tick",   CH'(tick_a), 4'b0000);
        chk("lit_reset_rise",   rise_a, 4'b0000);

        // Release with pb all ones: every channel flips together after edge 5.
        reset_n = 1'b1;
        repeat (5) step();
        chk("lit_release_hold", semnal_a, 4'b0000);
        step();
        chk("lit_release_flip", semnal_a, 4'b1111);
        chk("lit_release_rise", rise_a, EDGE_EN ? 4'b1111 : 4'b0000);
        step();
        chk("lit_release_rise_gone", rise_a, 4'b0000);
        pb_a = '0;
        repeat (8) step();

        // Clean press on channel 0.
        pb_a = 4'b0001;
        repeat (5) step();
        chk("lit_press_hold", semnal_a, 4'b0000);
        step();
        chk("lit_press_flip", semnal_a, 4'b0001);
        chk("lit_press_rise", rise_a, EDGE_EN ? 4'b0001 : 4'b0000);
        step();
        chk("lit_press_rise_one", rise_a, 4'b0000);
        repeat (3) step();

        // Three-cycle glitch on channel 1 is rejected.
        pb_a = 4'b0011;
        repeat (3) step();
        pb_a = 4'b0001;
        repeat (10) step();
        chk("lit_glitch_rejected", semnal_a, 4'b0001);

        // Four-cycle pulse is accepted, then released.
        pb_a = 4'b0011;
        repeat (4) step();
        pb_a = 4'b0001;
        repeat (2) step();
        chk("lit_pulse4_flip", semnal_a, 4'b0011);
        chk("lit_pulse4_rise", rise_a, EDGE_EN ? 4'b0010 : 4'b0000);
        repeat (4) step();
        chk("lit_pulse4_fall", fall_a, EDGE_EN ? 4'b0010 : 4'b0000);
        chk("lit_pulse4_released", semnal_a, 4'b0001);
        repeat (3) step();

        // clear one cycle before the flip postpones it by a full STABLE_TICKS.
        pb_a = 4'b0101;
        repeat (4) step();
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        step();
        chk("lit_clear_no_flip", semnal_a, 4'b0001);
        repeat (2) step();
        chk("lit_clear_still_held", semnal_a, 4'b0001);
        step();
        chk("lit_clear_late_flip", semnal_a, 4'b0101);
        repeat (2) step();

        // All channels toggle at once.
        pb_a = 4'b1010;
        repeat (6) step();
        chk("lit_simul_flip", semnal_a, 4'b1010);
        chk("lit_simul_rise", rise_a, EDGE_EN ? 4'b1010 : 4'b0000);
        chk("lit_simul_fall", fall_a, EDGE_EN ? 4'b0101 : 4'b0000);
        repeat (2) step();

        // Prescaled instance: tick period and stable release.
        chk("lit_b_settled_high", semnal_b, 4'b1111);
        pb_b = '0;
        nt = 0;
        repeat (20) begin
            step();
            nt += int'(tick_b);
        end
        chk("lit_b_tick_count", CH'(nt), 4'd4);
        chk("lit_b_release", semnal_b, 4'b0000);

        // Two-tick press on the prescaled instance does not flip.
        pb_b = 4'b0001;
        repeat (10) step();
        pb_b = '0;
        repeat (20) step();
        chk("lit_b_short_press", semnal_b, 4'b0000);

        // Long press on the prescaled instance does.
        pb_b = 4'b0001;
        repeat (20) step();
        chk("lit_b_long_press", semnal_b, 4'b0001);

        // Reset in the middle of a count discards it.
        pb_a = 4'b1111;
        repeat (3) step();
        reset_n = 1'b0;
        repeat (2) step();
        chk("lit_midreset_a", semnal_a, 4'b0000);
        chk("lit_midreset_b", semnal_b, 4'b0000);
        reset_n = 1'b1;
        repeat (8) step();
        chk("lit_after_midreset", semnal_a, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
